// File: rtl/muldiv_unit32.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit32
//  Description : Iterative 32-bit multiply/divide unit with HI/LO registers.
//                MULT/MULTU by shift-add, DIV/DIVU by restoring division,
//                one iteration per clock, sharing one 64-bit accumulator and
//                one 32-bit operand register. Signed operations work on
//                magnitudes and fix signs when the result is written.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit32 #(
    parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF,
    parameter int          ITERS   = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Counter value seen on the edge that performs the last iteration.
    localparam logic [5:0] LAST_COUNT = 6'(ITERS - 1);

    state_t      state;
    state_t      state_next;
    logic [5:0]  count;
    logic [63:0] acc;        // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] operand;    // mul: multiplicand magnitude; div: divisor magnitude
    logic        is_div;
    logic        div_zero;
    logic        neg_lo;     // negate 64-bit product (mul) or quotient (div)
    logic        neg_hi;     // negate remainder (div)

    // Operand sign handling: op[0]==0 selects the signed variants.
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic        launch_zero;

    assign rs_neg      = ~op[0] & rs_data[31];
    assign rt_neg      = ~op[0] & rt_data[31];
    assign rs_mag      = rs_neg ? (32'd0 - rs_data) : rs_data;
    assign rt_mag      = rt_neg ? (32'd0 - rt_data) : rt_data;
    assign launch_zero = op[1] & (rt_data == 32'd0);

    // One shift-add multiply step: add multiplicand when the low bit is set, shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // One restoring divide step: shift left, subtract divisor if it fits, set quotient bit.
    logic [32:0] div_upper;
    logic        div_fits;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    assign div_upper = acc[63:31];
    assign div_fits  = div_upper >= {1'b0, operand};
    assign div_diff  = div_upper[31:0] - operand;
    assign div_next  = div_fits ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

    // Final results with sign correction applied.
    logic [63:0] mul_result;
    logic [31:0] quot_result;
    logic [31:0] rem_result;
    assign mul_result  = neg_lo ? (64'd0 - acc) : acc;
    assign quot_result = neg_lo ? (32'd0 - acc[31:0]) : acc[31:0];
    assign rem_result  = neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: launch on start, leave RUN after the last iteration.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == LAST_COUNT) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, iterations, HI/LO write-back and register moves.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= 6'd0;
            acc      <= 64'd0;
            operand  <= 32'd0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= 6'd0;
                        is_div   <= op[1];
                        div_zero <= launch_zero;
                        if (op[1]) begin
                            // Divide by zero runs on the raw dividend so the
                            // remainder half ends up holding rs_data unchanged.
                            acc     <= {32'd0, launch_zero ? rs_data : rs_mag};
                            operand <= rt_mag;
                            neg_lo  <= ~launch_zero & (rs_neg ^ rt_neg);
                            neg_hi  <= ~launch_zero & rs_neg;
                        end else begin
                            acc     <= {32'd0, rt_mag};
                            operand <= rs_mag;
                            neg_lo  <= rs_neg ^ rt_neg;
                            neg_hi  <= 1'b0;
                        end
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                RUN: begin
                    count <= count + 6'd1;
                    acc   <= is_div ? div_next : mul_next;
                end
                FIN: begin
                    count <= 6'd0;
                    done  <= 1'b1;
                    if (!is_div) begin
                        hi <= mul_result[63:32];
                        lo <= mul_result[31:0];
                    end else if (div_zero) begin
                        hi <= acc[63:32];
                        lo <= DIV0_LO;
                    end else begin
                        hi <= rem_result;
                        lo <= quot_result;
                    end
                end
                default: begin
                    count <= 6'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit32
//  Description : Self-checking bench for muldiv_unit32 with a 64-bit
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int total  = 0;

    muldiv_unit32 #(.DIV0_LO(32'hFFFFFFFF), .ITERS(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clock = ~clock;

    // Reference: plain 64-bit integer arithmetic (truncating signed division).
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0]     p;
        logic [63:0]     q;
        logic [63:0]     r;
        p = 64'd0; q = 64'd0; r = 64'd0;
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = ua * ub;
            2'b10: if (b != 32'd0) begin q = sa / sb; r = sa % sb; end
            default: if (b != 32'd0) begin q = ua / ub; r = ua % ub; end
        endcase
        if (!o[1]) begin
            eh = p[63:32]; el = p[31:0];
        end else if (b == 32'd0) begin
            eh = a; el = 32'hFFFFFFFF;
        end else begin
            eh = r[31:0]; el = q[31:0];
        end
    endfunction

    // Launch one operation and follow it to completion; optionally scribble
    // on every input while busy to show the latched operands are used.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input string name);
        logic [31:0] eh, el, hold_hi, hold_lo;
        int cyc;
        bit stable;
        model(o, a, b, eh, el);
        @(negedge clock);
        hold_hi = hi; hold_lo = lo;
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0; stable = 1'b1;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (hi !== hold_hi || lo !== hold_lo || done !== 1'b0) stable = 1'b0;
            if (disturb) begin
                start = 1'($urandom); op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
                mthi = 1'($urandom); mtlo = 1'($urandom);
            end
            @(negedge clock);
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        total++;
        if (cyc !== 33) $display("FAIL %s busy_cycles: got %0d, want 33", name, cyc); else passed++;
        total++;
        if (done !== 1'b1) $display("FAIL %s done_pulse: got %b, want 1", name, done); else passed++;
        total++;
        if (hi !== eh) $display("FAIL %s hi: got %h, want %h", name, hi, eh); else passed++;
        total++;
        if (lo !== el) $display("FAIL %s lo: got %h, want %h", name, lo, el); else passed++;
        total++;
        if (!stable) $display("FAIL %s hold_while_busy: hi/lo/done changed before result (%h/%h)", name, hold_hi, hold_lo); else passed++;
        @(negedge clock);
        total++;
        if (done !== 1'b0) $display("FAIL %s done_width: got %b, want 0", name, done); else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b, want 0", busy); else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b, want 0", done); else passed++;
        total++;
        if (hi !== 32'd0) $display("FAIL reset_hi: got %h, want 0", hi); else passed++;
        total++;
        if (lo !== 32'd0) $display("FAIL reset_lo: got %h, want 0", lo); else passed++;
    endtask

    task automatic test_directed();
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
        total++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) $display("FAIL multu_max_const: got %h%h, want fffffffe00000001", hi, lo); else passed++;
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 1'b0, "mult_neg");
        total++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) $display("FAIL mult_neg_const: got %h%h, want ffffffffffffffeb", hi, lo); else passed++;
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, "div_neg");
        total++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_neg_const: got %h%h, want fffffffffffffffd", hi, lo); else passed++;
        run_op(2'b11, 32'd100, 32'd7, 1'b1, "divu_100_7_disturbed");
        total++;
        if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu_const: got hi=%0d lo=%0d, want hi=2 lo=14", hi, lo); else passed++;
        run_op(2'b11, 32'h00000064, 32'd0, 1'b0, "divu_by_zero");
        run_op(2'b10, 32'h80000000, 32'd0, 1'b0, "div_by_zero_neg");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_overflow");
        total++;
        if (lo !== 32'h80000000 || hi !== 32'd0) $display("FAIL div_overflow_const: got hi=%h lo=%h, want 0/80000000", hi, lo); else passed++;
        run_op(2'b00, 32'h80000000, 32'h80000000, 1'b0, "mult_minint");
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            run_op(o, a, b, (i % 2) == 1, "random");
        end
    endtask

    task automatic test_reset_abort();
        int seen_done;
        int cyc;
        @(negedge clock);
        op = 2'b01; rs_data = 32'hFFFFFFFF; rt_data = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (cyc < 10 && busy === 1'b1) begin
            @(negedge clock);
            cyc++;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %b, want 0", busy); else passed++;
        total++;
        if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL abort_hilo: got %h/%h, want 0/0", hi, lo); else passed++;
        seen_done = 0;
        repeat (40) begin
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
            @(negedge clock);
        end
        total++;
        if (seen_done != 0) $display("FAIL abort_no_done: got %0d active cycles, want 0", seen_done); else passed++;
        run_op(2'b01, 32'd6, 32'd7, 1'b0, "multu_after_abort");
        total++;
        if (lo !== 32'd42) $display("FAIL multu_6x7: got %0d, want 42", lo); else passed++;
    endtask

    task automatic test_moves();
        logic [31:0] hold_hi;
        int cyc;
        // Idle moves.
        @(negedge clock);
        rs_data = 32'h00001234; mthi = 1'b1;
        @(negedge clock);
        mthi = 1'b0;
        total++;
        if (hi !== 32'h00001234) $display("FAIL mthi_idle: got %h, want 00001234", hi); else passed++;
        rs_data = 32'hCAFEF00D; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b0;
        total++;
        if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) $display("FAIL mthi_mtlo_both: got %h/%h, want cafef00d", hi, lo); else passed++;
        // Move while busy is ignored.
        hold_hi = hi;
        op = 2'b01; rs_data = 32'd6; rt_data = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0; rs_data = 32'h00001234; mthi = 1'b1;
        repeat (3) @(negedge clock);
        mthi = 1'b0;
        total++;
        if (hi !== hold_hi) $display("FAIL mthi_busy: got %h, want %h", hi, hold_hi); else passed++;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
        total++;
        if (hi !== 32'd0 || lo !== 32'd42) $display("FAIL mthi_busy_result: got %h/%h, want 0/2a", hi, lo); else passed++;
        // Start and move in the same idle cycle: start wins.
        @(negedge clock);
        hold_hi = hi;
        op = 2'b01; rs_data = 32'h5555; rt_data = 32'd1; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clock);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        total++;
        if (hi !== hold_hi || lo !== 32'd42) $display("FAIL start_beats_move: got %h/%h, want %h/0000002a", hi, lo, hold_hi); else passed++;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
        total++;
        if (hi !== 32'd0 || lo !== 32'h5555) $display("FAIL start_beats_move_result: got %h/%h, want 0/5555", hi, lo); else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_moves();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit32.md
MULDIV_UNIT32 -- requirements
Module: muldiv_unit32

Interface
REQ-001 The block SHALL have parameter DIV0_LO, default 32'hFFFFFFFF, giving the LO value written on divide-by-zero.
REQ-002 The block SHALL have parameter ITERS, default 32, giving the iteration count per operation (one per cycle); ITERS other than 32 is unsupported.
REQ-003 The block SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  launch operation; sampled only in IDLE.
REQ-006 The block SHALL have port op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 The block SHALL have port rs_data  input  32  multiplicand/dividend, from register-file read port 1.
REQ-008 The block SHALL have port rt_data  input  32  multiplier/divisor, from register-file read port 2.
REQ-009 The block SHALL have port mthi  input  1  write rs_data to HI (MTHI).
REQ-010 The block SHALL have port mtlo  input  1  write rs_data to LO (MTLO).
REQ-011 The block SHALL have port busy  output  1  operation in progress; the pipeline stalls MFHI/MFLO/start while high.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-013 The block SHALL have port hi  output  32  HI register (product high word / remainder).
REQ-014 The block SHALL have port lo  output  32  LO register (product low word / quotient).

Function
REQ-015 The block SHALL implement states IDLE, RUN, FIN; IDLE->RUN on start, RUN->FIN after ITERS iterations, FIN->IDLE unconditionally.
REQ-016 The block SHALL latch op, rs_data and rt_data on the IDLE edge where start=1; later input changes SHALL have no effect.
REQ-017 The block SHALL hold busy=1 in RUN and FIN and busy=0 in IDLE.
REQ-018 The block SHALL take start at edge E0 and perform one iteration per edge from E1 through E32 using a 6-bit counter, write HI/LO at E33, and hold done=1 for exactly the cycle after E33.
REQ-019 The block SHALL implement MULTU as 32-bit shift-add, yielding a 64-bit product with HI=[63:32] and LO=[31:0].
REQ-020 The block SHALL implement MULT on operand magnitudes and apply two's-complement negation to the 64-bit result when the operand signs differ.
REQ-021 The block SHALL implement DIVU as restoring division, with LO=quotient and HI=remainder.
REQ-022 The block SHALL implement DIV on magnitudes, negating the quotient when the signs differ and giving the remainder the sign of the dividend (truncation toward zero).
REQ-023 On divide-by-zero, the block SHALL keep the same latency, write HI=latched rs_data and LO=DIV0_LO, and pulse done.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0, and SHALL raise no other flag.
REQ-025 The block SHALL ignore start while busy=1: no relaunch and no change to the latched operands.
REQ-026 When busy=0, mthi/mtlo SHALL write rs_data to HI/LO at the next edge; both may be asserted in the same cycle.
REQ-027 When busy=1, the block SHALL ignore mthi/mtlo.
REQ-028 When start and mthi/mtlo are asserted in the same IDLE cycle, start SHALL win and the moves SHALL be discarded.
REQ-029 HI/LO SHALL change only on an mthi/mtlo write, at E33, or on reset; intermediate iteration state SHALL NOT be visible on hi/lo.
REQ-030 The block SHALL keep the multiplication and division datapaths in shared 64-bit accumulator/shift registers plus a 32-bit operand register.

Reset
REQ-031 When reset=1 at a rising edge, the block SHALL force state=IDLE, counter=0, hi=0, lo=0, busy=0 and done=0, overriding all other inputs.
REQ-032 Reset during RUN or FIN SHALL abort the operation without any done pulse and without writing a partial result; the first start after reset releases SHALL behave normally.

Verification
REQ-033 The bench SHALL apply MULTU 0xFFFFFFFF x 0xFFFFFFFF and require busy for 33 cycles, then done with hi=0xFFFFFFFE and lo=0x00000001.
REQ-034 The bench SHALL apply MULT 0xFFFFFFFD (-3) x 0x00000007 and require hi=0xFFFFFFFF and lo=0xFFFFFFEB (-21).
REQ-035 The bench SHALL apply DIV 0xFFFFFFF9 (-7) / 0x00000002 and require lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1); with DIVU 100/7 it SHALL require lo=14 and hi=2.
REQ-036 The bench SHALL apply DIVU 0x00000064 / 0 and require done at the normal latency with hi=0x00000064 and lo=0xFFFFFFFF.
REQ-037 The bench SHALL assert reset on the 10th RUN cycle of a MULTU and require busy=0, hi=lo=0 and no done pulse; a subsequent MULTU 6x7 SHALL give lo=42.
REQ-038 The bench SHALL assert start and change rs_data mid-operation and require both to be ignored; mthi with rs_data=0x1234 while busy SHALL leave hi unchanged, while mthi with 0x1234 when idle SHALL give hi=0x00001234 next cycle.
